uno_dealer: RTL and testbench
=============================

Name: uno_dealer

Overview:
- Sequencing controller for the card deck datapath: starts the shuffle, deals the opening hands, then arbitrates draw requests from the players.
- Every draw reaches the deck as a series of single-card transactions, issued in round-robin order among requesting players.
- Sits between the game-control FSM / player logic and the deck block; it is the only master of the deck's start and draw inputs.

Parameters:
- NUM_PLAYERS, 4, number of requesters (2..4).
- HAND_SIZE, 7, cards dealt to each player at game start (1..15).
- TIMEOUT_CYC, 1023, maximum cycles to wait on any deck response before error (1..1023).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_start  in  1  new game; accepted only in S_IDLE or S_ERROR
- i_req  in  NUM_PLAYERS  per-player draw request, level
- i_req_cnt  in  2*NUM_PLAYERS  per-player count code: 00=1, 01=2, 10=4, 11 treated as 1
- o_req_ack  out  NUM_PLAYERS  one-cycle pulse when that player's full request is served
- o_deck_start  out  1  one-cycle shuffle pulse to deck
- o_deck_draw  out  3  draw command to deck; only 3'b000 or 3'b001 driven
- i_deck_done  in  1  deck idle/ready
- i_deck_drawn  in  1  deck card valid strobe
- i_deck_card  in  6  {color[1:0], value[3:0]}
- o_card_valid  out  1  one-cycle pulse, card delivered
- o_card  out  6  delivered card
- o_card_player  out  2  destination player index
- o_dealing  out  1  high during the opening deal
- o_busy  out  1  high in any state other than S_IDLE/S_READY/S_ERROR
- o_error  out  1  sticky deck-timeout flag

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. All outputs are 0; state S_IDLE; rr pointer 0; counters 0.
- S_IDLE: on i_start -> S_SHUF_REQ. i_req is ignored.
- S_SHUF_REQ: o_deck_start=1 for exactly one cycle; load guard=2 -> S_SHUF_WAIT.
- S_SHUF_WAIT: while guard>0, decrement it and ignore i_deck_done. After that, i_deck_done=1 -> S_DEAL with player=0, dealt=0.
- S_DEAL: o_dealing=1. Issue one single-card transaction to the current player.
  - After each card: player increments; on wrap to 0, dealt increments.
  - When dealt==HAND_SIZE -> S_READY. Total NUM_PLAYERS*HAND_SIZE cards, order p0,p1,..,pN-1 repeated.
- S_READY: pick the first requesting player at or after the rr pointer.
  - Latch that player and its count (1/2/4) -> S_SERVE.
  - No request -> stay. i_start here restarts the game (-> S_SHUF_REQ).
- S_SERVE: issue count single-card transactions to the latched player.
  - After the last one: o_req_ack[p] pulses for one cycle, rr pointer = p+1 mod NUM_PLAYERS -> S_READY.
  - Deasserting i_req mid-service does not abort it.
  - A player whose i_req is still high in the S_READY cycle after its ack is treated as a new request.
- Single-card transaction (substates TX_REQ, TX_REL):
  - TX_REQ: hold o_deck_draw=3'b001 until i_deck_drawn=1. In that cycle, capture i_deck_card -> TX_REL.
  - Next cycle: o_card_valid=1, o_card=captured card, o_card_player=destination.
  - TX_REL: o_deck_draw=0 until i_deck_done=1, then the transaction is complete.
  - Minimum 3 cycles per card.
- Timeout: a 10-bit counter runs in S_SHUF_WAIT, TX_REQ and TX_REL, and clears on every state/substate change.
  - Reaching TIMEOUT_CYC -> S_ERROR: o_error=1, deck outputs 0.
  - S_ERROR exits only on i_start (clears o_error, -> S_SHUF_REQ).
- i_start is ignored in S_SHUF_*, S_DEAL and S_SERVE.
- Reset mid-transaction drops the card in flight; the deck is reset on the same net.
- NUM_PLAYERS<4: upper o_card_player values are never produced.

Decomposition:
- Shared package (uno_pkg):
  - card_t: 6-bit struct {color, value}.
  - Color/value localparams (0..3 red/yellow/green/blue; 10 skip, 11 reverse, 12 draw two, 13 wild, 14 wild draw four).
  - Deck draw command encodings.
  - Dealer state enum.
- Sub-module uno_rr_arbiter: NUM_PLAYERS-wide request vector plus pointer in; one-hot grant and index out; purely combinational.

Test Plan:
- Start, NUM_PLAYERS=4, HAND_SIZE=7, deck model answers drawn 2 cycles after draw → exactly 1 o_deck_start pulse, 28 o_card_valid pulses, players 0,1,2,3 cyclic, then o_dealing=0 and o_busy=0.
- In S_READY, i_req=4'b0110, i_req_cnt p1=10, p2=00 → p1 receives 4 cards, then o_req_ack=4'b0010; then p2 receives 1 card, then o_req_ack=4'b0100; rr pointer=3.
- i_req p0 with cnt=01, dropped after 1 cycle → p0 still receives 2 cards and one ack.
- i_req_cnt=11 → exactly 1 card delivered.
- Deck model never asserts i_deck_drawn, TIMEOUT_CYC=15 → o_error rises 15 cycles after draw asserted; o_deck_draw=0; i_start clears o_error and issues o_deck_start.
- Assert i_rst_n low mid-S_SERVE → all outputs 0 asynchronously; after release, state S_IDLE; i_req ignored until i_start.

Source files
------------

// File: rtl/uno_pkg.sv
// Shared card, deck-command and dealer-state definitions for the card deck datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uno_pkg;

    typedef struct packed {
        logic [1:0] color;
        logic [3:0] value;
    } card_t;

    localparam logic [1:0] COLOR_RED    = 2'd0;
    localparam logic [1:0] COLOR_YELLOW = 2'd1;
    localparam logic [1:0] COLOR_GREEN  = 2'd2;
    localparam logic [1:0] COLOR_BLUE   = 2'd3;

    localparam logic [3:0] VAL_SKIP       = 4'd10;
    localparam logic [3:0] VAL_REVERSE    = 4'd11;
    localparam logic [3:0] VAL_DRAW_TWO   = 4'd12;
    localparam logic [3:0] VAL_WILD       = 4'd13;
    localparam logic [3:0] VAL_WILD_DRAW4 = 4'd14;

    localparam logic [2:0] DECK_CMD_IDLE = 3'b000;
    localparam logic [2:0] DECK_CMD_DRAW = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHUF_REQ,
        S_SHUF_WAIT,
        S_DEAL,
        S_READY,
        S_SERVE,
        S_ERROR
    } dealer_state_t;

    typedef enum logic {
        TX_REQ,
        TX_REL
    } tx_state_t;

    // Player count code: 00=1, 01=2, 10=4, 11 falls back to 1.
    function automatic logic [2:0] req_count(input logic [1:0] code);
        case (code)
            2'b01:   req_count = 3'd2;
            2'b10:   req_count = 3'd4;
            default: req_count = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/uno_rr_arbiter.sv
// Round-robin pick of the first requester at or after the pointer.
// Latency: combinational.
// Backpressure: none; grant is valid only while grant_vld is high.
module uno_rr_arbiter
    import uno_pkg::*;
#(
    parameter int NUM_PLAYERS = 4
) (
    input  logic [NUM_PLAYERS-1:0] req,
    input  logic [1:0]             ptr,
    output logic [NUM_PLAYERS-1:0] grant,
    output logic [1:0]             grant_idx,
    output logic                   grant_vld
);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cand = (int'(ptr) + i) % NUM_PLAYERS;
            if (!grant_vld && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand[1:0];
                grant_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uno_dealer.sv
// Dealer sequencer: shuffle, opening deal, then round-robin single-card draws per player request.
// Latency: >=3 cycles per card; card pulse one cycle after the deck strobe; ack one cycle after last card.
// Backpressure: waits on deck done/drawn handshakes; any wait reaching TIMEOUT_CYC parks in S_ERROR.
module uno_dealer
    import uno_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int HAND_SIZE   = 7,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [NUM_PLAYERS-1:0]     i_req,
    input  logic [2*NUM_PLAYERS-1:0]   i_req_cnt,
    output logic [NUM_PLAYERS-1:0]     o_req_ack,
    output logic                       o_deck_start,
    output logic [2:0]                 o_deck_draw,
    input  logic                       i_deck_done,
    input  logic                       i_deck_drawn,
    input  logic [5:0]                 i_deck_card,
    output logic                       o_card_valid,
    output logic [5:0]                 o_card,
    output logic [1:0]                 o_card_player,
    output logic                       o_dealing,
    output logic                       o_busy,
    output logic                       o_error
);

    localparam logic [1:0] LAST_PLAYER = 2'(NUM_PLAYERS - 1);
    localparam logic [3:0] HAND_LAST   = 4'(HAND_SIZE - 1);
    localparam logic [9:0] TMO_LAST    = 10'(TIMEOUT_CYC - 1);

    dealer_state_t          state_q, state_d;
    tx_state_t              tx_q, tx_d;
    logic [1:0]             guard_q;
    logic [1:0]             player_q;
    logic [3:0]             dealt_q;
    logic [1:0]             sel_q;
    logic [NUM_PLAYERS-1:0] sel_oh_q;
    logic [2:0]             rem_q;
    logic [1:0]             rr_ptr_q;
    logic [9:0]             tmo_q;
    card_t                  card_q;

    logic [NUM_PLAYERS-1:0] arb_grant;
    logic [1:0]             arb_idx;
    logic                   arb_vld;
    logic [1:0]             cnt_code;

    logic in_txn, drawn_now, txn_done, waiting, timeout;
    logic [1:0] dest;

    uno_rr_arbiter #(.NUM_PLAYERS(NUM_PLAYERS)) u_arb (
        .req       (i_req),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign cnt_code = i_req_cnt[{arb_idx, 1'b0} +: 2];

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        in_txn    = (state_q == S_DEAL) || (state_q == S_SERVE);
        drawn_now = in_txn && (tx_q == TX_REQ) && i_deck_drawn;
        // The card pulse cycle is the deck's release cycle, so done is not trusted until after it.
        txn_done  = in_txn && (tx_q == TX_REL) && i_deck_done && !o_card_valid;
        waiting   = (state_q == S_SHUF_WAIT) || in_txn;
        timeout   = waiting && (tmo_q >= TMO_LAST);
        dest      = (state_q == S_DEAL) ? player_q : sel_q;

        case (state_q)
            S_IDLE:      if (i_start) state_d = S_SHUF_REQ;
            S_SHUF_REQ:  state_d = S_SHUF_WAIT;
            S_SHUF_WAIT: if (guard_q == 2'd0 && i_deck_done) state_d = S_DEAL;
            S_DEAL: begin
                if (drawn_now) begin
                    tx_d = TX_REL;
                end else if (txn_done) begin
                    tx_d = TX_REQ;
                    if (player_q == LAST_PLAYER && dealt_q == HAND_LAST) state_d = S_READY;
                end
            end
            S_READY: begin
                if (i_start)      state_d = S_SHUF_REQ;
                else if (arb_vld) state_d = S_SERVE;
            end
            S_SERVE: begin
                if (drawn_now) begin
                    tx_d = TX_REL;
                end else if (txn_done) begin
                    tx_d = TX_REQ;
                    if (rem_q == 3'd1) state_d = S_READY;
                end
            end
            S_ERROR:     if (i_start) state_d = S_SHUF_REQ;
            default:     state_d = S_IDLE;
        endcase

        if (timeout && state_d == state_q && tx_d == tx_q) begin
            state_d = S_ERROR;
            tx_d    = TX_REQ;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            tx_q          <= TX_REQ;
            guard_q       <= '0;
            player_q      <= '0;
            dealt_q       <= '0;
            sel_q         <= '0;
            sel_oh_q      <= '0;
            rem_q         <= '0;
            rr_ptr_q      <= '0;
            tmo_q         <= '0;
            card_q        <= '0;
            o_card_valid  <= 1'b0;
            o_card_player <= '0;
            o_req_ack     <= '0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            o_card_valid <= drawn_now;
            o_req_ack    <= '0;

            if (state_d != state_q || tx_d != tx_q) tmo_q <= '0;
            else if (waiting)                       tmo_q <= tmo_q + 10'd1;

            if (state_q == S_SHUF_REQ)                         guard_q <= 2'd2;
            else if (state_q == S_SHUF_WAIT && guard_q != 2'd0) guard_q <= guard_q - 2'd1;

            if (state_q != S_DEAL && state_d == S_DEAL) begin
                player_q <= '0;
                dealt_q  <= '0;
            end else if (state_q == S_DEAL && txn_done) begin
                if (player_q == LAST_PLAYER) begin
                    player_q <= '0;
                    dealt_q  <= dealt_q + 4'd1;
                end else begin
                    player_q <= player_q + 2'd1;
                end
            end

            if (state_q == S_READY && state_d == S_SERVE) begin
                sel_q    <= arb_idx;
                sel_oh_q <= arb_grant;
                rem_q    <= req_count(cnt_code);
            end else if (state_q == S_SERVE && txn_done) begin
                rem_q <= rem_q - 3'd1;
                if (rem_q == 3'd1) begin
                    o_req_ack <= sel_oh_q;
                    rr_ptr_q  <= (sel_q == LAST_PLAYER) ? 2'd0 : sel_q + 2'd1;
                end
            end

            if (drawn_now) begin
                card_q        <= card_t'(i_deck_card);
                o_card_player <= dest;
            end
        end
    end

    assign o_card       = card_q;
    assign o_deck_start = (state_q == S_SHUF_REQ);
    assign o_deck_draw  = ((state_q == S_DEAL || state_q == S_SERVE) && tx_q == TX_REQ)
                          ? DECK_CMD_DRAW : DECK_CMD_IDLE;
    assign o_dealing    = (state_q == S_DEAL);
    assign o_busy       = !(state_q == S_IDLE || state_q == S_READY || state_q == S_ERROR);
    assign o_error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_uno_dealer.sv
// Bench for uno_dealer: directed stimulus pushes expected cards/acks; a negedge monitor pops and compares.
// A small deck model answers draws and can be muted to force a timeout.
module tb_uno_dealer;

    localparam int NP  = 4;
    localparam int HS  = 7;
    localparam int TMO = 15;

    typedef struct {
        logic [5:0] card;
        logic [1:0] player;
        logic       dealing;
    } exp_card_t;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [NP-1:0] i_req;
    logic [2*NP-1:0] i_req_cnt;
    logic [NP-1:0] o_req_ack;
    logic          o_deck_start;
    logic [2:0]    o_deck_draw;
    logic          deck_done;
    logic          deck_drawn;
    logic [5:0]    deck_card;
    logic          o_card_valid;
    logic [5:0]    o_card;
    logic [1:0]    o_card_player;
    logic          o_dealing;
    logic          o_busy;
    logic          o_error;

    exp_card_t   sb_card[$];
    logic [NP-1:0] sb_ack[$];
    int checks, failures, exp_seq, cards_seen, start_pulses;
    logic deck_mute;

    uno_dealer #(.NUM_PLAYERS(NP), .HAND_SIZE(HS), .TIMEOUT_CYC(TMO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_req         (i_req),
        .i_req_cnt     (i_req_cnt),
        .o_req_ack     (o_req_ack),
        .o_deck_start  (o_deck_start),
        .o_deck_draw   (o_deck_draw),
        .i_deck_done   (deck_done),
        .i_deck_drawn  (deck_drawn),
        .i_deck_card   (deck_card),
        .o_card_valid  (o_card_valid),
        .o_card        (o_card),
        .o_card_player (o_card_player),
        .o_dealing     (o_dealing),
        .o_busy        (o_busy),
        .o_error       (o_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_card(input int player, input logic dealing);
        exp_card_t e;
        e.card    = exp_seq[5:0];
        e.player  = player[1:0];
        e.dealing = dealing;
        sb_card.push_back(e);
        exp_seq++;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((sb_card.size() != 0 || sb_ack.size() != 0 || o_busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(n < budget), 1);
    endtask

    task automatic wait_ack_drop(input string name, input int p, input int budget);
        int n;
        n = 0;
        while (!o_req_ack[p] && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        i_req[p] = 1'b0;
        check(name, 32'(n < budget), 1);
    endtask

    // Deck model: shuffle takes 3 cycles, a draw is answered 2 cycles after it is seen.
    initial begin
        int phase, wcnt, seq;
        deck_done = 1'b1; deck_drawn = 1'b0; deck_card = '0;
        phase = 0; wcnt = 0; seq = 0;
        forever begin
            @(posedge clk); #1;
            deck_drawn = 1'b0;
            if (!rst_n) begin
                phase = 0; seq = 0; deck_done = 1'b1;
            end else if (o_deck_start) begin
                phase = 1; wcnt = 3; deck_done = 1'b0;
            end else begin
                case (phase)
                    1: begin
                        wcnt--;
                        if (wcnt == 0) begin phase = 0; deck_done = 1'b1; end
                    end
                    0: if (o_deck_draw == 3'b001) begin deck_done = 1'b0; wcnt = 2; phase = 2; end
                    2: if (!deck_mute) begin
                        wcnt--;
                        if (wcnt == 0) begin
                            deck_drawn = 1'b1; deck_card = seq[5:0]; seq++; phase = 3;
                        end
                    end
                    3: if (o_deck_draw == 3'b000) begin deck_done = 1'b1; phase = 0; end
                    default: phase = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (o_deck_start) start_pulses++;
        if (o_card_valid) begin
            cards_seen++;
            if (sb_card.size() == 0) begin
                check("card_unexpected", 0, 1);
            end else begin
                exp_card_t e;
                e = sb_card.pop_front();
                check("card_value", o_card, e.card);
                check("card_player", o_card_player, e.player);
                check("card_dealing", o_dealing, e.dealing);
            end
        end
        if (o_req_ack != '0) begin
            if (sb_ack.size() == 0) check("ack_unexpected", 0, 1);
            else check("req_ack", o_req_ack, sb_ack.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, base, busy_seen;
        checks = 0; failures = 0; exp_seq = 0; cards_seen = 0; start_pulses = 0;
        rst_n = 1'b0; i_start = 1'b0; i_req = '0; i_req_cnt = '0; deck_mute = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_deck_start", o_deck_start, 0);
        check("rst_deck_draw", o_deck_draw, 0);
        check("rst_card_valid", o_card_valid, 0);
        check("rst_req_ack", o_req_ack, 0);
        check("rst_busy_err_deal", {o_busy, o_error, o_dealing}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Opening deal: 28 cards, p0..p3 cyclic.
        for (int i = 0; i < NP * HS; i++) push_card(i % NP, 1'b1);
        pulse_start();
        wait_idle("deal1_done", 1000);
        check("deal1_start_pulses", start_pulses, 1);
        check("deal1_cards", cards_seen, 28);
        check("deal1_dealing_low", o_dealing, 0);
        check("deal1_busy_low", o_busy, 0);

        // p1 asks for 4, p2 for 1.
        i_req_cnt[3:2] = 2'b10; i_req_cnt[5:4] = 2'b00;
        for (int i = 0; i < 4; i++) push_card(1, 1'b0);
        sb_ack.push_back(4'b0010);
        push_card(2, 1'b0);
        sb_ack.push_back(4'b0100);
        i_req = 4'b0110;
        wait_ack_drop("ack_p1_seen", 1, 200);
        wait_ack_drop("ack_p2_seen", 2, 200);
        wait_idle("serve12_done", 200);

        // Pointer now at 3: p3 beats p0.
        i_req_cnt[1:0] = 2'b00; i_req_cnt[7:6] = 2'b00;
        push_card(3, 1'b0); sb_ack.push_back(4'b1000);
        push_card(0, 1'b0); sb_ack.push_back(4'b0001);
        i_req = 4'b1001;
        wait_ack_drop("ack_p3_seen", 3, 200);
        wait_ack_drop("ack_p0_seen", 0, 200);
        wait_idle("serve30_done", 200);

        // One-cycle request for 2 cards still completes.
        i_req_cnt[1:0] = 2'b01;
        push_card(0, 1'b0); push_card(0, 1'b0); sb_ack.push_back(4'b0001);
        i_req[0] = 1'b1;
        @(posedge clk); #1;
        i_req[0] = 1'b0;
        wait_idle("short_req_done", 200);

        // Code 11 means a single card.
        i_req_cnt[5:4] = 2'b11;
        push_card(2, 1'b0); sb_ack.push_back(4'b0100);
        i_req[2] = 1'b1;
        wait_ack_drop("ack_code11_seen", 2, 200);
        wait_idle("code11_done", 200);
        check("cards_before_tmo", cards_seen, 38);

        // Deck goes silent: error 15 cycles after the draw starts.
        deck_mute = 1'b1;
        i_req[3] = 1'b1;
        n = 0;
        while (o_deck_draw != 3'b001 && n < 20) begin @(posedge clk); #1; n++; end
        check("tmo_draw_seen", 32'(n < 20), 1);
        i_req[3] = 1'b0;
        n = 0;
        while (!o_error && n < 100) begin @(posedge clk); #1; n++; end
        check("tmo_cycles", n, 15);
        check("tmo_deck_draw", o_deck_draw, 0);
        check("tmo_busy", o_busy, 0);
        deck_mute = 1'b0;
        for (int i = 0; i < NP * HS; i++) push_card(i % NP, 1'b1);
        pulse_start();
        check("restart_error_clr", o_error, 0);
        check("restart_deck_start", o_deck_start, 1);
        wait_idle("deal2_done", 1000);

        // Reset in the middle of a 4-card serve.
        i_req_cnt[1:0] = 2'b10;
        for (int i = 0; i < 4; i++) push_card(0, 1'b0);
        sb_ack.push_back(4'b0001);
        base = cards_seen;
        i_req[0] = 1'b1;
        n = 0;
        while (cards_seen < base + 2 && n < 200) begin @(posedge clk); #1; n++; end
        check("mid_serve_reached", 32'(n < 200), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_deck_draw", o_deck_draw, 0);
        check("arst_busy", o_busy, 0);
        check("arst_card_valid", o_card_valid, 0);
        check("arst_card", {o_card, o_card_player}, 0);
        check("arst_misc", {o_req_ack, o_deck_start, o_dealing, o_error}, 0);
        check("arst_inflight_left", sb_card.size(), 2);
        sb_card.delete();
        sb_ack.delete();
        exp_seq = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (o_busy || o_deck_draw != 3'b000) busy_seen++;
        end
        check("post_rst_req_ignored", busy_seen, 0);

        i_req = '0;
        for (int i = 0; i < NP * HS; i++) push_card(i % NP, 1'b1);
        pulse_start();
        wait_idle("deal3_done", 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
